// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types, encodings and decode helpers for the multi-cycle RV32I control unit (ILLEGAL_TRAP_EN adds the HALT state)
package mc_ctrl_pkg;

    localparam int STATE_W = 4;

`ifdef ILLEGAL_TRAP_EN
    typedef enum logic [STATE_W-1:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_HALT
    } state_t;
    localparam state_t S_BADOP = S_HALT;
`else
    typedef enum logic [STATE_W-1:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
    } state_t;
    localparam state_t S_BADOP = S_FETCH;
`endif

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALURESULT = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALUOUT    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // Moore outputs of each state; anything not set stays at its zero default
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write  = 1'b1;
                c.pc_update = 1'b1;
                c.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.result_src = RES_ALUOUT;
                c.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.result_src = RES_ALUOUT;
                c.adr_src    = 1'b1;
                c.mem_write  = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = SRCA_A;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = SRCA_A;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Sequencing rules; unknown encodings fall back to FETCH
    function automatic state_t next_state(input state_t s, input logic [6:0] op);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:  n = S_DECODE;
            S_DECODE: n = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                          (op == OP_R)   ? S_EXECUTER :
                          (op == OP_I)   ? S_EXECUTEI :
                          (op == OP_BEQ) ? S_BEQ :
                          (op == OP_JAL) ? S_JAL : S_BADOP;
            S_MEMADR:   n = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  n = S_MEMWB;
            S_EXECUTER: n = S_ALUWB;
            S_EXECUTEI: n = S_ALUWB;
            S_JAL:      n = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
            S_HALT:     n = S_HALT;
`endif
            default:    n = S_FETCH;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// mc_control_unit_if: decode/status inputs and datapath controls between control unit (master) and datapath (slave)
interface mc_control_unit_if;

    logic [6:0] Op;
    logic [2:0] fun3;
    logic       fun75;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       Illegal;

    modport master (
        input  Op, fun3, fun75, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal
    );

    modport slave (
        output Op, fun3, fun75, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal
    );

endinterface

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: maps ALUOp plus funct fields to the ALU operation code
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_fun3,
    input  logic       i_fun75,
    input  logic       i_op5,
    output logic [2:0] o_alu_control
);

    logic [2:0] w_funct;

    // Only R-type with Instr[30] set subtracts; I-type never does (no subi)
    always_comb begin
        w_funct = (i_fun3 == 3'b000) ? ((i_op5 & i_fun75) ? ALUC_SUB : ALUC_ADD) :
                  (i_fun3 == 3'b010) ? ALUC_SLT :
                  (i_fun3 == 3'b110) ? ALUC_OR :
                  (i_fun3 == 3'b111) ? ALUC_AND : ALUC_ADD;
        o_alu_control = (i_alu_op == ALUOP_SUB)   ? ALUC_SUB :
                        (i_alu_op == ALUOP_FUNCT) ? w_funct : ALUC_ADD;
    end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: Moore control FSM of the multi-cycle RV32I core (ILLEGAL_TRAP_EN enables HALT on unsupported opcodes)
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
)(
    input logic Clk,
    input logic Rst_n,
    mc_control_unit_if.master bus
);

    logic [STATE_W-1:0] r_state;
    ctrl_t              r_ctrl;
    state_t             w_state;
    state_t             w_next;
    logic [1:0]         w_imm_src;
    logic [2:0]         w_alu_control;

    assign w_state = state_t'(r_state);
    assign w_next  = next_state(w_state, bus.Op);

    // State and its Moore outputs advance together, so the outputs are always those of r_state
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= S_FETCH;
            r_ctrl  <= ctrl_of(S_FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_of(w_next);
        end
    end

    // Immediate format tracks the live opcode: J for jal target, S for store address
    always_comb begin
        w_imm_src = (w_state == S_DECODE) ? ((bus.Op == OP_JAL) ? IMM_J : IMM_B) :
                    (w_state == S_MEMADR && bus.Op == OP_SW) ? IMM_S : IMM_I;
    end

    mc_alu_decoder u_alu_dec (
        .i_alu_op      (r_ctrl.alu_op),
        .i_fun3        (bus.fun3),
        .i_fun75       (bus.fun75),
        .i_op5         (bus.Op[5]),
        .o_alu_control (w_alu_control)
    );

    // Enables are masked by reset so an abandoned instruction cannot write in the reset cycle
    assign bus.PCWrite    = Rst_n & (r_ctrl.pc_update | (r_ctrl.branch & bus.Zero));
    assign bus.MemWrite   = Rst_n & r_ctrl.mem_write;
    assign bus.IRWrite    = Rst_n & r_ctrl.ir_write;
    assign bus.RegWrite   = Rst_n & r_ctrl.reg_write;
    assign bus.AdrSrc     = r_ctrl.adr_src;
    assign bus.ResultSrc  = r_ctrl.result_src;
    assign bus.ALUSrcA    = r_ctrl.alu_src_a;
    assign bus.ALUSrcB    = r_ctrl.alu_src_b;
    assign bus.ImmSrc     = w_imm_src;
    assign bus.ALUControl = w_alu_control;

`ifdef ILLEGAL_TRAP_EN
    assign bus.Illegal = (w_state == S_HALT);
`else
    assign bus.Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: per-instruction cycle model checked against mc_control_unit every cycle (honours ILLEGAL_TRAP_EN)
module tb_mc_control_unit;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] BAD  = 7'b1111111;

    localparam int L_PCW = 0, L_RW = 1, L_MW = 2, L_ALUC = 3, L_ILL = 4, L_IMM = 5, L_IRW = 6, L_ADR = 7;

    typedef struct {
        logic       pcu, br, adr, mw, irw, rw, ill, z, rst;
        logic [1:0] res, sa, sb, imm;
        logic [2:0] aluc;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t cur;

    mc_control_unit_if bus();

    mc_control_unit dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic cmp(input string nm, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ncyc(input logic [6:0] op);
        return (op == LW) ? 5 : (op == BEQ) ? 3 :
               (op == SW || op == RT || op == IT || op == JAL) ? 4 : 2;
    endfunction

    // Expected outputs for cycle k of one instruction, straight from the per-instruction rules
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                                   input logic z, input int k);
        exp_t e;
        logic [2:0] fa;
        e = '{default: '0};
        fa = (f3 == 3'd0) ? ((op[5] & f75) ? 3'd1 : 3'd0) :
             (f3 == 3'd2) ? 3'd5 : (f3 == 3'd6) ? 3'd3 : (f3 == 3'd7) ? 3'd2 : 3'd0;
        if (k == 0) begin
            e.irw = 1; e.pcu = 1; e.sb = 2;
        end else if (k == 1) begin
            e.sa = 1; e.sb = 1; e.imm = (op == JAL) ? 2'd3 : 2'd2;
        end else if (op == LW || op == SW) begin
            if (k == 2) begin e.sa = 2; e.sb = 1; e.imm = (op == SW) ? 2'd1 : 2'd0; end
            else if (k == 3) begin e.res = 2; e.adr = 1; e.mw = (op == SW); end
            else begin e.res = 1; e.rw = 1; end
        end else if (op == RT || op == IT) begin
            if (k == 2) begin e.sa = 2; e.sb = (op == IT) ? 2'd1 : 2'd0; e.aluc = fa; end
            else begin e.res = 2; e.rw = 1; end
        end else if (op == BEQ) begin
            e.sa = 2; e.aluc = 1; e.res = 2; e.br = 1;
        end else if (op == JAL) begin
            if (k == 2) begin e.sa = 1; e.sb = 2; e.res = 2; e.pcu = 1; end
            else begin e.res = 2; e.rw = 1; end
        end else begin
            e.ill = 1;
        end
        e.z = z;
        return e;
    endfunction

    // Compare every cycle that has an expectation queued
    always @(negedge Clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            cmp("PCWrite", {2'b0, bus.PCWrite}, {2'b0, (cur.pcu | (cur.br & cur.z)) & ~cur.rst});
            cmp("MemWrite", {2'b0, bus.MemWrite}, {2'b0, cur.mw & ~cur.rst});
            cmp("IRWrite", {2'b0, bus.IRWrite}, {2'b0, cur.irw & ~cur.rst});
            cmp("RegWrite", {2'b0, bus.RegWrite}, {2'b0, cur.rw & ~cur.rst});
            if (!cur.rst) begin
                cmp("AdrSrc", {2'b0, bus.AdrSrc}, {2'b0, cur.adr});
                cmp("ResultSrc", {1'b0, bus.ResultSrc}, {1'b0, cur.res});
                cmp("ALUSrcA", {1'b0, bus.ALUSrcA}, {1'b0, cur.sa});
                cmp("ALUSrcB", {1'b0, bus.ALUSrcB}, {1'b0, cur.sb});
                cmp("ImmSrc", {1'b0, bus.ImmSrc}, {1'b0, cur.imm});
                cmp("ALUControl", bus.ALUControl, cur.aluc);
                cmp("Illegal", {2'b0, bus.Illegal}, {2'b0, cur.ill});
            end
        end
    end

    task automatic lit(input int sel, input logic [2:0] v);
        case (sel)
            L_PCW:   cmp("lit_PCWrite", {2'b0, bus.PCWrite}, v);
            L_RW:    cmp("lit_RegWrite", {2'b0, bus.RegWrite}, v);
            L_MW:    cmp("lit_MemWrite", {2'b0, bus.MemWrite}, v);
            L_ALUC:  cmp("lit_ALUControl", bus.ALUControl, v);
            L_ILL:   cmp("lit_Illegal", {2'b0, bus.Illegal}, v);
            L_IMM:   cmp("lit_ImmSrc", {1'b0, bus.ImmSrc}, v);
            L_IRW:   cmp("lit_IRWrite", {2'b0, bus.IRWrite}, v);
            default: cmp("lit_AdrSrc", {2'b0, bus.AdrSrc}, v);
        endcase
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75, input logic z,
                             input int n, input int lk, input int ls, input logic [2:0] lv);
        for (int k = 0; k < n; k++) begin
            bus.Op = op; bus.fun3 = f3; bus.fun75 = f75; bus.Zero = z;
            q.push_back(model(op, f3, f75, z, k));
            if (k == lk) begin
                #2;
                lit(ls, lv);
            end
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic rst_cycle();
        exp_t e;
        e = '{default: '0};
        e.rst = 1;
        Rst_n = 1'b0;
        q.push_back(e);
        #2;
        cmp("rst_enables", {bus.PCWrite | bus.MemWrite, bus.IRWrite, bus.RegWrite}, 3'b000);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    initial begin
        exp_t m;
        bus.Op = LW; bus.fun3 = 3'd0; bus.fun75 = 1'b0; bus.Zero = 1'b0;
        m = model(RT, 3'd0, 1'b1, 1'b0, 2);
        cmp("mdl_r_sub", m.aluc, 3'b001);
        m = model(IT, 3'd0, 1'b1, 1'b0, 2);
        cmp("mdl_addi", m.aluc, 3'b000);
        m = model(LW, 3'd2, 1'b0, 1'b0, 4);
        cmp("mdl_lw_wb", {m.rw, m.res}, 3'b101);
        m = model(SW, 3'd2, 1'b0, 1'b0, 3);
        cmp("mdl_sw_mem", {m.mw, m.adr, m.rw}, 3'b110);
        cmp("mdl_lw_len", 3'(ncyc(LW)), 3'd5);
        cmp("mdl_beq_len", 3'(ncyc(BEQ)), 3'd3);
        @(posedge Clk);
        #1;
        rst_cycle();
        Rst_n = 1'b0;
        rst_cycle();
        run_instr(LW, 3'd2, 1'b0, 1'b0, 5, 0, L_PCW, 3'd1);
        run_instr(LW, 3'd2, 1'b0, 1'b0, 5, 4, L_RW, 3'd1);
        run_instr(SW, 3'd2, 1'b0, 1'b0, 4, 2, L_IMM, 3'd1);
        run_instr(SW, 3'd2, 1'b0, 1'b0, 4, 3, L_MW, 3'd1);
        run_instr(RT, 3'd0, 1'b1, 1'b0, 4, 2, L_ALUC, 3'b001);
        run_instr(IT, 3'd0, 1'b1, 1'b0, 4, 2, L_ALUC, 3'b000);
        run_instr(RT, 3'd2, 1'b0, 1'b0, 4, 2, L_ALUC, 3'b101);
        run_instr(RT, 3'd6, 1'b0, 1'b0, 4, 2, L_ALUC, 3'b011);
        run_instr(IT, 3'd7, 1'b0, 1'b0, 4, 2, L_ALUC, 3'b010);
        run_instr(RT, 3'd1, 1'b1, 1'b0, 4, 2, L_ALUC, 3'b000);
        run_instr(RT, 3'd0, 1'b0, 1'b0, 4, 3, L_RW, 3'd1);
        run_instr(BEQ, 3'd0, 1'b0, 1'b1, 3, 2, L_PCW, 3'd1);
        run_instr(BEQ, 3'd0, 1'b0, 1'b0, 3, 2, L_PCW, 3'd0);
        run_instr(JAL, 3'd0, 1'b0, 1'b0, 4, 1, L_IMM, 3'd3);
        run_instr(LW, 3'd2, 1'b0, 1'b0, 4, 3, L_ADR, 3'd1);
        rst_cycle();
        run_instr(SW, 3'd2, 1'b0, 1'b0, 4, 0, L_IRW, 3'd1);
`ifdef ILLEGAL_TRAP_EN
        run_instr(BAD, 3'd0, 1'b0, 1'b1, 14, 13, L_ILL, 3'd1);
        rst_cycle();
`else
        run_instr(BAD, 3'd0, 1'b0, 1'b1, 2, 1, L_ILL, 3'd0);
`endif
        run_instr(IT, 3'd6, 1'b0, 1'b0, 4, 0, L_IRW, 3'd1);
        run_instr(BEQ, 3'd0, 1'b0, 1'b1, 3, 0, L_PCW, 3'd1);
        @(posedge Clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
